nios_system_led_pio_blink: RTL and testbench

- Parametrised Avalon-MM slave output port. It is the next generation of the fixed-width LED output PIO used on the Nios system bus.
- Adds atomic SET/CLEAR/TOGGLE writes, so software no longer needs read-modify-write sequences.
- Adds a per-bit hardware blink mode driven by an internal programmable prescaler, so LEDs can flash without CPU involvement.
- Sits on the system interconnect alongside the other PIOs and drives board LEDs through out_port.

---
 rtl/nios_system_led_pio_blink_pkg.sv | 11 +
 rtl/nios_system_led_pio_blink_if.sv | 11 +
 rtl/nios_system_led_blink_timer.sv | 28 ++
 rtl/nios_system_led_pio_blink.sv | 68 ++++++
 tb/tb_nios_system_led_pio_blink.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_led_pio_blink_pkg.sv
// rtl/nios_system_led_pio_blink_pkg.sv - register map constants for the blinking LED PIO
package nios_system_led_pio_blink_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TGL    = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam int PHASE_BIT = 0;
endpackage

// File: rtl/nios_system_led_pio_blink_if.sv
// rtl/nios_system_led_pio_blink_if.sv - Avalon-MM slave register bus
interface nios_system_led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_led_blink_timer.sv
// rtl/nios_system_led_blink_timer.sv - prescaler producing the blink phase
module nios_system_led_blink_timer #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                phase
);
  logic [PERIOD_W-1:0] cnt;

  // A period load restarts the half-period and wins over a coincident wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load || period == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period - PERIOD_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end
endmodule

// File: rtl/nios_system_led_pio_blink.sv
// rtl/nios_system_led_pio_blink.sv - LED output PIO with atomic bit ops and hardware blink
module nios_system_led_pio_blink
  import nios_system_led_pio_blink_pkg::*;
#(
  parameter int                  WIDTH        = 9,
  parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
  parameter int                  PERIOD_W     = 26,
  parameter logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(25000000)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  nios_system_led_pio_blink_if.slave    bus,
  output logic [WIDTH-1:0]              out_port
);
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic                wr_en;
  logic [WIDTH-1:0]    wd;
  logic [31:0]         rd;
  logic                unused_wd;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RESET_VALUE;
      mask   <= '0;
      period <= PERIOD_RESET;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DATA:   data   <= wd;
        ADDR_SET:    data   <= data | wd;
        ADDR_CLR:    data   <= data & ~wd;
        ADDR_TGL:    data   <= data ^ wd;
        ADDR_MASK:   mask   <= wd;
        ADDR_PERIOD: period <= bus.writedata[PERIOD_W-1:0];
        default: ;
      endcase
    end
  end

  nios_system_led_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .load    (wr_en && bus.address == ADDR_PERIOD),
    .phase   (phase)
  );

  // DATA reads back the stored value, not the blinked drive.
  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_DATA:   rd[WIDTH-1:0]    = data;
      ADDR_MASK:   rd[WIDTH-1:0]    = mask;
      ADDR_PERIOD: rd[PERIOD_W-1:0] = period;
      ADDR_STATUS: rd[PHASE_BIT]    = phase;
      default:     rd = '0;
    endcase
  end

  assign bus.readdata = rd;
  assign out_port     = data ^ (mask & {WIDTH{phase}});
endmodule

// File: tb/tb_nios_system_led_pio_blink.sv
// tb/tb_nios_system_led_pio_blink.sv - randomized model-checked bench for the blinking LED PIO
module tb_nios_system_led_pio_blink;
  import nios_system_led_pio_blink_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios_system_led_pio_blink_if bus ();
  nios_system_led_pio_blink_if bus1 ();
  nios_system_led_pio_blink_if bus32 ();
  logic [8:0]  out_port;
  logic [0:0]  out1;
  logic [31:0] out32;

  nios_system_led_pio_blink #(.WIDTH(9), .RESET_VALUE(9'h0A5)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port));
  nios_system_led_pio_blink #(.WIDTH(1), .RESET_VALUE(1'b1), .PERIOD_W(1), .PERIOD_RESET(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .out_port(out1));
  nios_system_led_pio_blink #(.WIDTH(32), .RESET_VALUE(32'hDEAD_BEEF), .PERIOD_W(32),
                              .PERIOD_RESET(32'd0)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32), .out_port(out32));

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: phase derived from elapsed cycles since the last period load.
  logic [8:0]  m_data, m_mask;
  logic [25:0] m_per;
  int          t;

  function automatic logic m_phase();
    if (m_per == '0) return 1'b0;
    return ((t / int'(m_per)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a);
    case (a)
      3'd0: return {23'd0, m_data};
      3'd4: return {23'd0, m_mask};
      3'd5: return {6'd0, m_per};
      3'd6: return {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 9'h0A5; m_mask = '0; m_per = 26'd25000000; t = 0;
    end else begin
      t++;
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: m_data = bus.writedata[8:0];
          3'd1: m_data = m_data | bus.writedata[8:0];
          3'd2: m_data = m_data & ~bus.writedata[8:0];
          3'd3: m_data = m_data ^ bus.writedata[8:0];
          3'd4: m_mask = bus.writedata[8:0];
          3'd5: begin m_per = bus.writedata[25:0]; t = 0; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_port", {23'd0, out_port}, {23'd0, m_data ^ (m_mask & {9{m_phase()}})});
      chk("readdata", bus.readdata, m_read(bus.address));
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(string name, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a; #1;
    chk(name, bus.readdata, exp);
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    bus32.address = '0; bus32.chipselect = 1'b0; bus32.write_n = 1'b1; bus32.writedata = '0;
    idle(3);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    idle(1);

    chk("reset out_port", {23'd0, out_port}, 32'h0000_00A5);
    rd_chk("reset data", ADDR_DATA, 32'h0000_00A5);
    rd_chk("reset period", ADDR_PERIOD, 32'd25000000);
    rd_chk("reset status", ADDR_STATUS, 32'd0);
    rd_chk("reset mask", ADDR_MASK, 32'd0);

    wr(ADDR_DATA, 32'h0000_00F0);
    wr(ADDR_SET, 32'h0000_0003);
    rd_chk("set", ADDR_DATA, 32'h0000_00F3);
    wr(ADDR_CLR, 32'hFFFF_FE30);
    rd_chk("clear", ADDR_DATA, 32'h0000_00C3);
    wr(ADDR_TGL, 32'hABCD_E101);
    rd_chk("toggle", ADDR_DATA, 32'h0000_01C2);
    rd_chk("read set", ADDR_SET, 32'd0);
    rd_chk("read clr", ADDR_CLR, 32'd0);
    rd_chk("read tgl", ADDR_TGL, 32'd0);
    wr(ADDR_SET, 32'd0); wr(ADDR_CLR, 32'd0); wr(ADDR_TGL, 32'd0);
    rd_chk("zero ops", ADDR_DATA, 32'h0000_01C2);

    wr(ADDR_DATA, 32'h0); wr(ADDR_MASK, 32'h00F); wr(ADDR_PERIOD, 32'd4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("blink0", {23'd0, out_port}, (i < 4) ? 32'h000 : 32'h00F);
    end
    @(posedge clk); #1;
    wr(ADDR_DATA, 32'h001);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_port != 9'h001) chk("blink1 value", {23'd0, out_port}, 32'h00E);
      else chk("blink1 value", {23'd0, out_port}, 32'h001);
    end
    @(posedge clk); #1;

    wr(ADDR_PERIOD, 32'd4);
    idle(3);
    wr(ADDR_PERIOD, 32'd3);
    rd_chk("wrap load phase", ADDR_STATUS, 32'd0);
    idle(2);
    rd_chk("pre toggle phase", ADDR_STATUS, 32'd0);
    idle(1);
    rd_chk("post toggle phase", ADDR_STATUS, 32'd1);

    wr(ADDR_PERIOD, 32'd0);
    idle(20);
    rd_chk("period0 phase", ADDR_STATUS, 32'd0);
    chk("period0 out", {23'd0, out_port}, 32'h001);
    wr(ADDR_PERIOD, 32'd1);
    idle(1);
    rd_chk("period1 a", ADDR_STATUS, 32'd1);
    idle(1);
    rd_chk("period1 b", ADDR_STATUS, 32'd0);

    wr(ADDR_DATA, 32'h055);
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a); bus.writedata = $urandom; bus.chipselect = 1'b0; bus.write_n = 1'b0;
      idle(1);
    end
    bus.write_n = 1'b1;
    rd_chk("cs low data", ADDR_DATA, 32'h055);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("addr7 read", 3'd7, 32'd0);
    rd_chk("addr7 data", ADDR_DATA, 32'h055);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == ADDR_PERIOD) d = (d & 32'hFC00_0000) | 32'($urandom_range(0, 5));
      bus.address = a; bus.writedata = d;
      bus.chipselect = 1'($urandom_range(0, 3) != 0);
      bus.write_n = 1'($urandom_range(0, 1));
      idle(1);
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;

    wr(ADDR_DATA, 32'h0); wr(ADDR_MASK, 32'h0F); wr(ADDR_PERIOD, 32'd1);
    idle(1);
    #2 reset_n = 1'b0;
    #1 chk("async reset out", {23'd0, out_port}, 32'h0A5);
    bus.address = ADDR_PERIOD; #1;
    chk("async reset period", bus.readdata, 32'd25000000);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    bus1.address = ADDR_DATA; bus32.address = ADDR_DATA; #1;
    chk("w1 reset", bus1.readdata, 32'h1);
    chk("w32 reset", bus32.readdata, 32'hDEAD_BEEF);
    bus1.writedata = 32'hFFFF_FFFE; bus32.writedata = 32'h1234_5678;
    bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus32.chipselect = 1'b1; bus32.write_n = 1'b0;
    idle(1);
    bus1.address = ADDR_PERIOD; bus32.address = ADDR_PERIOD;
    bus1.writedata = 32'hFFFF_FFFF; bus32.writedata = 32'hFFFF_FFFF;
    idle(1);
    bus1.chipselect = 1'b0; bus32.chipselect = 1'b0;
    bus1.write_n = 1'b1; bus32.write_n = 1'b1;
    #1;
    chk("w1 period", bus1.readdata, 32'h1);
    chk("w32 period", bus32.readdata, 32'hFFFF_FFFF);
    bus1.address = ADDR_DATA; bus32.address = ADDR_DATA; #1;
    chk("w1 data", bus1.readdata, 32'h0);
    chk("w32 data", bus32.readdata, 32'h1234_5678);
    chk("w32 out", out32, 32'h1234_5678);
    chk("w1 out", {31'd0, out1}, 32'h0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
